// File: rtl/lcd_host_if.sv
// Host-side command issuer and IRAM image capture for the LCD controller.
// Opcodes are queued in a small FIFO, issued under busy, and a WRITE frame is captured into a 64x8 image.
module lcd_host_if #(
    parameter int CMD_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_iram_valid,
    input  logic [5:0] lcd_iram_a,
    input  logic [7:0] lcd_iram_d,
    input  logic       lcd_done,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic       cmd_err
);

    localparam int AW = $clog2(CMD_DEPTH);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_ISSUE,
        ST_GAP,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]    fifo_mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full, empty, push, pop;
    logic [3:0]    head;

    logic          wr_seen_reg;
    logic [3:0]    lcd_cmd_reg, lcd_cmd_next;
    logic          lcd_cmd_valid_reg, lcd_cmd_valid_next;
    logic [6:0]    write_cnt_reg, write_cnt_next;
    logic          cap_we, drop;
    logic          frame_done_reg, frame_done_set;
    logic          frame_err_reg, frame_err_set;
    logic          cmd_err_reg;
    logic [7:0]    img_reg [64];
    logic [7:0]    rd_data_reg;

    assign full     = (count_reg == (AW+1)'(CMD_DEPTH));
    assign empty    = (count_reg == '0);
    assign in_ready = !full && !wr_seen_reg;
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            wr_seen_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && in_cmd == 4'd0) begin
                wr_seen_reg <= 1'b1;
            end
        end
    end

    // GAP re-samples busy and may issue directly, so back-to-back commands land two cycles apart.
    always_comb begin
        state_next         = state_reg;
        lcd_cmd_next       = lcd_cmd_reg;
        lcd_cmd_valid_next = 1'b0;
        write_cnt_next     = write_cnt_reg;
        pop                = 1'b0;
        drop               = 1'b0;
        cap_we             = 1'b0;
        frame_done_set     = 1'b0;
        frame_err_set      = 1'b0;
        case (state_reg)
            ST_WAIT, ST_GAP: begin
                state_next    = ST_WAIT;
                frame_err_set = lcd_iram_valid;
                if (!lcd_busy && !empty) begin
                    pop = 1'b1;
                    if (head >= 4'd12) begin
                        drop = 1'b1;
                    end else begin
                        lcd_cmd_next       = head;
                        lcd_cmd_valid_next = 1'b1;
                        state_next         = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                frame_err_set = lcd_iram_valid;
                state_next    = (lcd_cmd_reg == 4'd0) ? ST_CAPTURE : ST_GAP;
            end
            ST_CAPTURE: begin
                cap_we = lcd_iram_valid;
                if (cap_we && write_cnt_reg != 7'd127) begin
                    write_cnt_next = write_cnt_reg + 7'd1;
                end
                if (lcd_done) begin
                    state_next = ST_DONE;
                    if (write_cnt_next == 7'd64) begin
                        frame_done_set = 1'b1;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                frame_err_set = lcd_iram_valid;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_WAIT;
            lcd_cmd_reg       <= 4'd0;
            lcd_cmd_valid_reg <= 1'b0;
            write_cnt_reg     <= 7'd0;
            frame_done_reg    <= 1'b0;
            frame_err_reg     <= 1'b0;
            cmd_err_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            lcd_cmd_reg       <= lcd_cmd_next;
            lcd_cmd_valid_reg <= lcd_cmd_valid_next;
            write_cnt_reg     <= write_cnt_next;
            if (frame_done_set) begin
                frame_done_reg <= 1'b1;
            end
            if (frame_err_set) begin
                frame_err_reg <= 1'b1;
            end
            if (drop) begin
                cmd_err_reg <= 1'b1;
            end
        end
    end

    // Image kept in flops so that reset can clear every entry at once.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_img
            always_ff @(posedge clk) begin
                if (reset) begin
                    img_reg[gi] <= 8'd0;
                end else if (cap_we && lcd_iram_a == 6'(gi)) begin
                    img_reg[gi] <= lcd_iram_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= 8'd0;
        end else begin
            rd_data_reg <= img_reg[rd_addr];
        end
    end

    assign lcd_cmd       = lcd_cmd_reg;
    assign lcd_cmd_valid = lcd_cmd_valid_reg;
    assign rd_data       = rd_data_reg;
    assign frame_done    = frame_done_reg;
    assign frame_err     = frame_err_reg;
    assign cmd_err       = cmd_err_reg;

endmodule

// File: tb/tb_lcd_host_if.sv
// Directed bench for lcd_host_if: issue ordering, FIFO full, illegal opcodes, capture and readback.
module tb_lcd_host_if;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_iram_valid;
    logic [5:0] lcd_iram_a;
    logic [7:0] lcd_iram_d;
    logic       lcd_done;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic       frame_err;
    logic       cmd_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    int         stb_n;
    int         stb_t   [16];
    logic [3:0] stb_cmd [16];

    lcd_host_if #(.CMD_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_cmd         (in_cmd),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .lcd_cmd        (lcd_cmd),
        .lcd_cmd_valid  (lcd_cmd_valid),
        .lcd_busy       (lcd_busy),
        .lcd_iram_valid (lcd_iram_valid),
        .lcd_iram_a     (lcd_iram_a),
        .lcd_iram_d     (lcd_iram_d),
        .lcd_done       (lcd_done),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs n cycles, logging every issue strobe with its cycle index (1 = first edge).
    task automatic collect(input int n);
        stb_n = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (lcd_cmd_valid && stb_n < 16) begin
                stb_t[stb_n]   = i;
                stb_cmd[stb_n] = lcd_cmd;
                stb_n++;
            end
        end
    endtask

    task automatic push_one(input logic [3:0] op);
        in_cmd   = op;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic write_frame(input int n, input logic [7:0] xor_key);
        for (int i = 0; i < n; i++) begin
            lcd_iram_valid = 1'b1;
            lcd_iram_a     = 6'(i);
            lcd_iram_d     = 8'(i) ^ xor_key;
            step();
        end
        lcd_iram_valid = 1'b0;
        lcd_done       = 1'b1;
        step();
        lcd_done       = 1'b0;
    endtask

    initial begin
        int vcount;
        int acc;
        reset          = 1'b1;
        in_cmd         = 4'd0;
        in_valid       = 1'b0;
        lcd_busy       = 1'b1;
        lcd_iram_valid = 1'b0;
        lcd_iram_a     = 6'd0;
        lcd_iram_d     = 8'd0;
        lcd_done       = 1'b0;
        rd_addr        = 6'd0;
        do_reset();

        // Reset state
        check_eq("rst_lcd_cmd", 32'(lcd_cmd), 32'd0);
        check_eq("rst_cmd_valid", 32'(lcd_cmd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_cmd_err", 32'(cmd_err), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Busy held: queue 4,1,7,0 and confirm nothing issues
        vcount = 0;
        push_one(4'd4); if (lcd_cmd_valid) vcount++;
        push_one(4'd1); if (lcd_cmd_valid) vcount++;
        push_one(4'd7); if (lcd_cmd_valid) vcount++;
        push_one(4'd0); if (lcd_cmd_valid) vcount++;
        check_eq("ready_after_write", 32'(in_ready), 32'd0);
        for (int i = 0; i < 66; i++) begin
            step();
            if (lcd_cmd_valid) vcount++;
        end
        check_eq("no_issue_busy", 32'(vcount), 32'd0);

        lcd_busy = 1'b0;
        collect(10);
        check_eq("issue_count", 32'(stb_n), 32'd4);
        check_eq("issue0_cmd", 32'(stb_cmd[0]), 32'd4);
        check_eq("issue0_t", 32'(stb_t[0]), 32'd1);
        check_eq("issue1_cmd", 32'(stb_cmd[1]), 32'd1);
        check_eq("issue1_t", 32'(stb_t[1]), 32'd3);
        check_eq("issue2_cmd", 32'(stb_cmd[2]), 32'd7);
        check_eq("issue2_t", 32'(stb_t[2]), 32'd5);
        check_eq("issue3_cmd", 32'(stb_cmd[3]), 32'd0);
        check_eq("issue3_t", 32'(stb_t[3]), 32'd7);

        // Full frame of 64 writes
        write_frame(64, 8'hA5);
        check_eq("frame_done_64", 32'(frame_done), 32'd1);
        check_eq("frame_err_64", 32'(frame_err), 32'd0);
        rd_addr = 6'd5;
        step();
        check_eq("rd_addr5", 32'(rd_data), 32'hA0);
        rd_addr = 6'd63;
        step();
        check_eq("rd_addr63", 32'(rd_data), 32'h9A);

        // FIFO full: 9 offers with busy high
        do_reset();
        lcd_busy = 1'b1;
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            in_cmd   = 4'(i + 1);
            in_valid = 1'b1;
            if (in_ready) acc++;
            step();
        end
        check_eq("fifo_accepted", 32'(acc), 32'd8);
        check_eq("fifo_full_ready", 32'(in_ready), 32'd0);
        lcd_busy = 1'b0;
        step();
        in_valid = 1'b0;
        check_eq("ready_after_pop", 32'(in_ready), 32'd1);
        check_eq("first_pop_cmd", 32'(lcd_cmd), 32'd1);
        collect(20);
        check_eq("drain_count", 32'(stb_n), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("drain%0d_cmd", i), 32'(stb_cmd[i]), 32'(i + 2));
        end

        // Illegal opcode is dropped
        in_cmd   = 4'd13;
        in_valid = 1'b1;
        step();
        in_cmd   = 4'd3;
        step();
        in_valid = 1'b0;
        collect(6);
        check_eq("illegal_issues", 32'(stb_n), 32'd1);
        check_eq("legal_after_drop", 32'(stb_cmd[0]), 32'd3);
        check_eq("cmd_err_set", 32'(cmd_err), 32'd1);

        // Strobe outside CAPTURE flags an error; done outside CAPTURE ignored
        do_reset();
        check_eq("cmd_err_cleared", 32'(cmd_err), 32'd0);
        lcd_iram_valid = 1'b1;
        lcd_done       = 1'b1;
        step();
        lcd_iram_valid = 1'b0;
        lcd_done       = 1'b0;
        check_eq("stray_strobe_err", 32'(frame_err), 32'd1);
        check_eq("stray_done_ign", 32'(frame_done), 32'd0);

        // Short frame: 0 then 5, 63 writes
        do_reset();
        push_one(4'd0);
        check_eq("ready_after_0", 32'(in_ready), 32'd0);
        in_cmd   = 4'd5;
        in_valid = 1'b1;
        collect(5);
        check_eq("short_issues", 32'(stb_n), 32'd1);
        check_eq("short_cmd", 32'(stb_cmd[0]), 32'd0);
        write_frame(63, 8'h00);
        in_valid = 1'b0;
        check_eq("short_err", 32'(frame_err), 32'd1);
        check_eq("short_done", 32'(frame_done), 32'd0);
        check_eq("five_never_ready", 32'(in_ready), 32'd0);

        // Reset mid-CAPTURE after 30 writes, then a clean frame
        do_reset();
        push_one(4'd0);
        step();
        step();
        for (int i = 0; i < 30; i++) begin
            lcd_iram_valid = 1'b1;
            lcd_iram_a     = 6'(i);
            lcd_iram_d     = 8'h11 + 8'(i);
            step();
        end
        lcd_iram_valid = 1'b0;
        rd_addr = 6'd3;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_rd_data", 32'(rd_data), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_cmd_valid", 32'(lcd_cmd_valid), 32'd0);
        check_eq("midrst_done", 32'(frame_done), 32'd0);
        check_eq("midrst_err", 32'(frame_err), 32'd0);
        step();
        check_eq("midrst_img_clr", 32'(rd_data), 32'd0);
        push_one(4'd0);
        step();
        step();
        write_frame(64, 8'hFF);
        check_eq("refr_done", 32'(frame_done), 32'd1);
        check_eq("refr_err", 32'(frame_err), 32'd0);
        rd_addr = 6'd10;
        step();
        check_eq("refr_rd10", 32'(rd_data), 32'hF5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
